y86_regfile_wb: RTL and testbench

Parametrised write-back register file for the Y86-64 pipeline: accepts the W-stage result bundle, commits up to two register writes per clock, and serves two combinational decode read ports. It tracks architectural status with a sticky halt, counts retired instructions, and exposes a registered debug read tap. It sits at the W/D boundary, replacing the fixed 15-entry register array with a sized, reset-able, stall-aware block.

---
 rtl/y86_regfile_wb_if.sv | 41 ++++
 rtl/y86_regfile_wb.sv | 142 ++++++++++++++
 tb/tb_y86_regfile_wb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/y86_regfile_wb_if.sv
// y86_regfile_wb_if: W-stage commit bundle, decode read ports, debug tap
// and status outputs of the Y86-64 write-back register file.
// The master side is the pipeline (and the testbench). The slave side is
// the register file.
interface y86_regfile_wb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
);
  // W-stage result bundle
  logic              W_stall;
  logic [3:0]        W_icode;
  logic [3:0]        W_stat;
  logic [ADDR_W-1:0] W_destE;
  logic [ADDR_W-1:0] W_destM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  // decode read ports
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  // debug tap and architectural status
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_val;
  logic              halt;
  logic [3:0]        stat_out;
  logic [CNT_W-1:0]  retired;

  modport master (
    output W_stall, W_icode, W_stat, W_destE, W_destM, W_valE, W_valM,
    output srcA, srcB, dbg_sel,
    input  valA, valB, dbg_val, halt, stat_out, retired
  );

  modport slave (
    input  W_stall, W_icode, W_stat, W_destE, W_destM, W_valE, W_valM,
    input  srcA, srcB, dbg_sel,
    output valA, valB, dbg_val, halt, stat_out, retired
  );
endinterface

// File: rtl/y86_regfile_wb.sv
// y86_regfile_wb: Y86-64 write-back register file.
// - Commits up to two writes per clock. The M port wins when both ports
//   target the same register.
// - Serves two combinational decode reads and a registered debug tap.
// - Keeps a sticky halt/status and a saturating retired-instruction count.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, valA/valB
// forward the same-cycle write data.
module y86_regfile_wb #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic rst,
  y86_regfile_wb_if.slave wb
);

  localparam logic [ADDR_W-1:0] RNONE     = '1;
  localparam logic [3:0]        STAT_AOK  = 4'd1;
  localparam logic [3:0]        ICODE_NOP = 4'd1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        stat_reg, stat_next;
  logic [CNT_W-1:0]  retired_reg;
  logic [DATA_W-1:0] dbg_reg;
  logic [DATA_W-1:0] regs_reg [NREGS];

  logic              commit;
  logic              fault_take;
  logic              we_e, we_m;
  logic [DATA_W-1:0] rd_a, rd_b, rd_dbg;

  // Specifiers at or above NREGS, and RNONE itself, address nothing.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != RNONE) && (int'(a) < NREGS);
  endfunction

  // Decide whether this cycle commits or traps on a non-AOK status.
  // Reset and stall both block the commit.
  always_comb begin
    commit     = !rst && !wb.W_stall && (state_reg == ST_RUN) && (wb.W_stat == STAT_AOK);
    fault_take = !rst && !wb.W_stall && (state_reg == ST_RUN) && (wb.W_stat != STAT_AOK);
    we_e       = commit && in_range(wb.W_destE);
    we_m       = commit && in_range(wb.W_destM);
  end

  // Next-state logic of the halt FSM. The trapping status is captured once
  // and then held until reset.
  always_comb begin
    state_next = state_reg;
    stat_next  = stat_reg;
    if (fault_take) begin
      state_next = ST_HALTED;
      stat_next  = wb.W_stat;
    end
  end

  // State register for the halt FSM and the latched status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      stat_reg  <= STAT_AOK;
    end else begin
      state_reg <= state_next;
      stat_reg  <= stat_next;
    end
  end

  // One flop row per architectural register. Each register resets to its
  // own index. The M port has priority so that popq %rsp leaves the popped
  // value in the register.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_reg[gi] <= DATA_W'(gi);
      end else if (we_m && (wb.W_destM == ADDR_W'(gi))) begin
        regs_reg[gi] <= wb.W_valM;
      end else if (we_e && (wb.W_destE == ADDR_W'(gi))) begin
        regs_reg[gi] <= wb.W_valE;
      end
    end
  end

  // Array read muxes. An out-of-range specifier reads as zero.
  always_comb begin
    rd_a   = '0;
    rd_b   = '0;
    rd_dbg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(wb.srcA) == i)    rd_a   = regs_reg[i];
      if (int'(wb.srcB) == i)    rd_b   = regs_reg[i];
      if (int'(wb.dbg_sel) == i) rd_dbg = regs_reg[i];
    end
  end

  // Decode read ports, with optional same-cycle forwarding (M before E).
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    if (we_m && (wb.W_destM == wb.srcA))      wb.valA = wb.W_valM;
    else if (we_e && (wb.W_destE == wb.srcA)) wb.valA = wb.W_valE;
    else                                      wb.valA = rd_a;
    if (we_m && (wb.W_destM == wb.srcB))      wb.valB = wb.W_valM;
    else if (we_e && (wb.W_destE == wb.srcB)) wb.valB = wb.W_valE;
    else                                      wb.valB = rd_b;
`else
    wb.valA = rd_a;
    wb.valB = rd_b;
`endif
  end

  // Retired-instruction counter. Only real (non-bubble) commits count, and
  // the counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (commit && (wb.W_icode != ICODE_NOP) && !(&retired_reg)) begin
      retired_reg <= retired_reg + 1'b1;
    end
  end

  // Debug tap captures the pre-write value. It freezes with the rest of the
  // state during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_reg <= '0;
    end else if (!wb.W_stall) begin
      dbg_reg <= rd_dbg;
    end
  end

  assign wb.dbg_val  = dbg_reg;
  assign wb.halt     = (state_reg == ST_HALTED);
  assign wb.stat_out = stat_reg;
  assign wb.retired  = retired_reg;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// tb_y86_regfile_wb: scoreboard testbench for y86_regfile_wb.
// The stimulus task drives one W bundle per cycle, updates a behavioural
// model of the architectural state and queues the expected outputs. A
// separate monitor samples the DUT every cycle and compares the outputs
// against the queued expectations.
module tb_y86_regfile_wb;

  localparam int DATA_W = 64;
  localparam int NREGS  = 15;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  y86_regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  y86_regfile_wb #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          chk_comb;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] dbg;
    logic        halt;
    logic [3:0]  stat;
    logic [1:0]  ret;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  // behavioural model of the architectural state
  logic [63:0] m_regs [NREGS];
  logic [63:0] m_dbg;
  bit          m_halt;
  logic [3:0]  m_stat;
  int          m_ret;
  bit          m_known = 0;

  function automatic logic [63:0] m_read(input logic [3:0] s);
    if (int'(s) < NREGS) return m_regs[s];
    return 64'd0;
  endfunction

  task automatic cyc(input bit r, input bit st, input logic [3:0] ic, input logic [3:0] sa,
                     input logic [3:0] de, input logic [3:0] dm,
                     input logic [63:0] ve, input logic [63:0] vm,
                     input logic [3:0] s_a, input logic [3:0] s_b, input logic [3:0] ds);
    exp_t e;
    bit we_e, we_m;
    @(negedge clk);
    rst = r;
    bus.W_stall = st; bus.W_icode = ic; bus.W_stat = sa;
    bus.W_destE = de; bus.W_destM = dm; bus.W_valE = ve; bus.W_valM = vm;
    bus.srcA = s_a; bus.srcB = s_b; bus.dbg_sel = ds;

    we_e = !r && !st && !m_halt && (sa == 4'd1) && (int'(de) < NREGS);
    we_m = !r && !st && !m_halt && (sa == 4'd1) && (int'(dm) < NREGS);

    e.id = txn_id;
    txn_id++;
    e.chk_comb = m_known;
    e.val_a = m_read(s_a);
    e.val_b = m_read(s_b);
`ifdef REGFILE_BYPASS_EN
    if (we_m && dm == s_a) e.val_a = vm; else if (we_e && de == s_a) e.val_a = ve;
    if (we_m && dm == s_b) e.val_b = vm; else if (we_e && de == s_b) e.val_b = ve;
`endif

    if (r) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 64'(i);
      m_dbg = 0; m_halt = 0; m_stat = 4'd1; m_ret = 0; m_known = 1;
    end else if (!st) begin
      m_dbg = m_read(ds);
      if (!m_halt) begin
        if (sa != 4'd1) begin
          m_halt = 1;
          m_stat = sa;
        end else begin
          if (we_e) m_regs[de] = ve;
          if (we_m) m_regs[dm] = vm;
          if (ic != 4'd1 && m_ret < CNT_MAX) m_ret++;
        end
      end
    end
    e.dbg = m_dbg; e.halt = m_halt; e.stat = m_stat; e.ret = 2'(m_ret);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn %0d: got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  // monitor: samples the combinational reads before the edge and the
  // registered outputs after it, then compares them with the queue head
  initial begin
    exp_t e;
    logic [63:0] a, b;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = bus.valA;
        b = bus.valB;
        @(posedge clk);
        #1;
        if (e.chk_comb) begin
          check("valA", e.id, a, e.val_a);
          check("valB", e.id, b, e.val_b);
        end
        check("dbg_val",  e.id, bus.dbg_val, e.dbg);
        check("halt",     e.id, 64'(bus.halt), 64'(e.halt));
        check("stat_out", e.id, 64'(bus.stat_out), 64'(e.stat));
        check("retired",  e.id, 64'(bus.retired), 64'(e.ret));
        $display("txn %0d valA=0x%0h valB=0x%0h dbg=0x%0h halt=%0b stat=%0d retired=%0d",
                 e.id, a, b, bus.dbg_val, bus.halt, bus.stat_out, bus.retired);
      end
    end
  end

  initial begin
    // reset, then read r5 and the dbg tap
    cyc(1, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd5, 4'd0, 4'd5);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd5, 4'd0, 4'd5);
    // dual write collision: the M port wins
    cyc(0, 0, 4'hB, 4'd1, 4'd4, 4'd4, 64'h10, 64'h20, 4'd4, 4'd3, 4'd4);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd4, 4'd4, 4'd4);
    // same-cycle read of a register being written
    cyc(0, 0, 4'h2, 4'd1, 4'd3, 4'hF, 64'hDEAD, 0, 4'd3, 4'd3, 4'd3);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd3, 4'd4, 4'd3);
    // stall blocks the write, then check r6/r7
    cyc(0, 1, 4'h2, 4'd1, 4'd6, 4'd7, 64'h66, 64'h77, 4'd6, 4'd7, 4'd6);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd6, 4'd7, 4'd7);
    // RNONE drops the write; a bubble write is not counted
    cyc(0, 0, 4'h2, 4'd1, 4'hF, 4'hF, 64'h55, 64'h56, 4'hF, 4'd14, 4'hF);
    cyc(0, 0, 4'h1, 4'd1, 4'd8, 4'hF, 64'h88, 0, 4'd8, 4'd9, 4'd8);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd8, 4'd9, 4'd8);
    // halt with a suppressed write; later AOK writes are ignored
    cyc(0, 0, 4'h0, 4'd2, 4'd2, 4'hF, 64'h99, 0, 4'd2, 4'd1, 4'd2);
    cyc(0, 0, 4'h2, 4'd1, 4'd2, 4'd1, 64'hAA, 64'hBB, 4'd2, 4'd1, 4'd2);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd2, 4'd1, 4'd1);
    // saturation, then a halt, then reset while halted
    cyc(1, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd0, 4'd1, 4'd0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 4'h6, 4'd1, 4'(i), 4'hF, 64'(100 + i), 0, 4'(i), 4'd10, 4'(i));
    cyc(0, 0, 4'h6, 4'd3, 4'hF, 4'hF, 0, 0, 4'd0, 4'd1, 4'd0);
    cyc(1, 0, 4'h6, 4'd1, 4'd0, 4'hF, 64'h1, 0, 4'd0, 4'd1, 4'd0);
    cyc(0, 0, 4'h1, 4'd1, 4'hF, 4'hF, 0, 0, 4'd0, 4'd4, 4'd1);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit r, st;
      logic [3:0] sa;
      r  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 4) == 0);
      sa = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      cyc(r, st, 4'($urandom_range(0, 15)), sa,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          {$urandom, $urandom}, {$urandom, $urandom},
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
